// File: rtl/arb_requester.sv
// arb_requester: client agent that requests the two-requester arbiter and issues a burst of beats
module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int WAIT_W  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             beat_last,
    output logic             done,
    output logic             timeout_err,
    output logic             abort_err
);
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        XFER    = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic              abort_q, abort_d;

    assign cmd_ready   = state_q == IDLE;
    assign req         = (state_q == REQ) || (state_q == XFER);
    assign beat_valid  = (state_q == XFER) && gnt;
    assign beat_idx    = beat_q;
    assign beat_last   = beat_valid && (beat_q == len_q);
    assign done        = done_q;
    assign timeout_err = tmo_q;
    assign abort_err   = abort_q;

    // Next-state logic; the pulse flags are raised only on the transition into RELEASE
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                len_d   = cmd_len;
                wait_d  = '0;
                state_d = REQ;
            end
            REQ: if (gnt) begin
                state_d = XFER;
                beat_d  = '0;
            end else if (wait_q == WAIT_MAX) begin
                state_d = RELEASE;
                tmo_d   = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
            XFER: if (!gnt) begin
                state_d = RELEASE;
                abort_d = 1'b1;
            end else if (beat_last) begin
                state_d = RELEASE;
                done_d  = 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
            RELEASE: if (!gnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: scoreboard bench for two requesters sharing a modelled arbiter
module tb_arb_requester;
    typedef struct packed {
        logic [3:0] f;
        logic [3:0] idx;
        logic       last;
    } ev_t;

    localparam logic [3:0] F_BEAT = 4'b1000;
    localparam logic [3:0] F_DONE = 4'b0100;
    localparam logic [3:0] F_TMO  = 4'b0010;
    localparam logic [3:0] F_ABT  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cv, cr, rq, g, bv, bl, dn, te, ae, ag;
    logic [3:0] cl [2];
    logic [3:0] bi [2];
    logic       gnt_drv, arb_mode, both_seen;
    ev_t        q0[$], q1[$];
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    assign g[0] = arb_mode ? ag[0] : gnt_drv;
    assign g[1] = arb_mode ? ag[1] : 1'b0;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        arb_requester u_dut (
            .clock(clk), .reset_n(rst_n), .cmd_valid(cv[i]), .cmd_len(cl[i]),
            .cmd_ready(cr[i]), .req(rq[i]), .gnt(g[i]), .beat_valid(bv[i]),
            .beat_idx(bi[i]), .beat_last(bl[i]), .done(dn[i]),
            .timeout_err(te[i]), .abort_err(ae[i])
        );
    end

    // Arbiter model: fixed priority to requester 0, holds grant until its req drops, then idles a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ag <= 2'b00;
        else if (ag == 2'b00) ag <= rq[0] ? 2'b01 : rq[1] ? 2'b10 : 2'b00;
        else if ((ag[0] && !rq[0]) || (ag[1] && !rq[1])) ag <= 2'b00;
    end

    // Record any cycle where both grants are high
    always @(negedge clk) if (arb_mode && g[0] && g[1]) both_seen = 1'b1;

    // Monitor: every output event is popped against the expected queue of its instance
    always @(negedge clk) begin : mon
        ev_t a, e;
        for (int k = 0; k < 2; k++) begin
            a.f    = {bv[k], dn[k], te[k], ae[k]};
            a.idx  = bv[k] ? bi[k] : 4'd0;
            a.last = bl[k];
            if (a.f != 4'd0 || a.last) begin
                total++;
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    bad++;
                    $display("FAIL ev%0d unexpected: got f=%b idx=%0d last=%b want none", k, a.f, a.idx, a.last);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    if (a !== e) begin
                        bad++;
                        $display("FAIL ev%0d: got f=%b idx=%0d last=%b want f=%b idx=%0d last=%b",
                                 k, a.f, a.idx, a.last, e.f, e.idx, e.last);
                    end
                end
            end
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, act, exp);
        end
    endtask

    function automatic void push(int k, logic [3:0] f, logic [3:0] idx, logic last);
        ev_t e;
        e = '{f: f, idx: idx, last: last};
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic void push_burst(int k, int len);
        for (int i = 0; i <= len; i++) push(k, F_BEAT, 4'(i), i == len);
        push(k, F_DONE, 4'd0, 1'b0);
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(int k, logic [3:0] len);
        cv[k] = 1'b1;
        cl[k] = len;
        tick(1);
        cv[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; cv = 2'b00; cl[0] = 4'd0; cl[1] = 4'd0;
        gnt_drv = 1'b0; arb_mode = 1'b0; both_seen = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rst_cmd_ready", 32'(cr[0]), 1);
        chk("rst_req", 32'(rq[0]), 0);
        chk("rst_beat", 32'({bv[0], bl[0], bi[0]}), 0);
        chk("rst_pulses", 32'({dn[0], te[0], ae[0]}), 0);

        issue(0, 4'd3);
        chk("basic_ready_low", 32'(cr[0]), 0);
        chk("basic_req_high", 32'(rq[0]), 1);
        push_burst(0, 3);
        tick(2);
        gnt_drv = 1'b1;
        tick(5);
        chk("basic_req_released", 32'(rq[0]), 0);
        tick(1);
        chk("basic_hold_release", 32'(cr[0]), 0);
        gnt_drv = 1'b0;
        tick(1);
        chk("basic_idle", 32'(cr[0]), 1);
        chk("basic_drained", 32'(q0.size()), 0);

        issue(0, 4'd2);
        push(0, F_TMO, 4'd0, 1'b0);
        n = 0;
        while (rq[0] && n < 40) begin
            n++;
            tick(1);
        end
        chk("tmo_req_cycles", 32'(n), 15);
        tick(1);
        chk("tmo_idle", 32'(cr[0]), 1);
        chk("tmo_drained", 32'(q0.size()), 0);

        issue(0, 4'd7);
        gnt_drv = 1'b1;
        for (int i = 0; i < 3; i++) push(0, F_BEAT, 4'(i), 1'b0);
        push(0, F_ABT, 4'd0, 1'b0);
        tick(4);
        gnt_drv = 1'b0;
        #1;
        chk("loss_no_beat", 32'(bv[0]), 0);
        tick(1);
        chk("loss_req_low", 32'(rq[0]), 0);
        tick(1);
        chk("loss_idle", 32'(cr[0]), 1);
        chk("loss_drained", 32'(q0.size()), 0);

        arb_mode = 1'b1;
        both_seen = 1'b0;
        push_burst(0, 1);
        push_burst(1, 1);
        cv = 2'b11; cl[0] = 4'd1; cl[1] = 4'd1;
        tick(1);
        cv = 2'b00;
        n = 0;
        while (!(cr == 2'b11 && q0.size() == 0 && q1.size() == 0) && n < 40) begin
            n++;
            tick(1);
        end
        chk("cont_finished", 32'(n < 40), 1);
        chk("cont_mutex", 32'(both_seen), 0);
        arb_mode = 1'b0;
        tick(2);

        issue(0, 4'd3);
        gnt_drv = 1'b1;
        push(0, F_BEAT, 4'd0, 1'b0);
        push(0, F_BEAT, 4'd1, 1'b0);
        tick(2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(rq[0]), 0);
        chk("arst_beat", 32'({bv[0], bl[0], bi[0]}), 0);
        chk("arst_pulses", 32'({dn[0], te[0], ae[0]}), 0);
        gnt_drv = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("arst_ready", 32'(cr[0]), 1);
        chk("arst_drained", 32'(q0.size()), 0);

        issue(0, 4'd15);
        gnt_drv = 1'b1;
        push_burst(0, 15);
        tick(17);
        gnt_drv = 1'b0;
        chk("long_req_low", 32'(rq[0]), 0);
        tick(1);
        chk("long_idle", 32'(cr[0]), 1);
        chk("long_drained", 32'(q0.size()), 0);

        issue(0, 4'd0);
        push_burst(0, 0);
        tick(14);
        chk("late_req_high", 32'(rq[0]), 1);
        gnt_drv = 1'b1;
        tick(2);
        gnt_drv = 1'b0;
        tick(1);
        chk("late_idle", 32'(cr[0]), 1);
        chk("late_drained", 32'(q0.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
